// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Purpose:
//   Instruction-fetch front end. The unit holds the PC, drives the instruction
//   ROM (chip enable plus byte address) and captures the word the ROM returns
//   combinationally. Each captured {pc, inst} pair goes into a small FIFO. The
//   decode stage drains that FIFO over a valid/ready handshake. A branch/jump
//   redirect reloads the PC and discards everything already fetched.
//
// Parameters:
//   RESET_PC    PC value loaded on reset.
//   FIFO_DEPTH  number of fetch-buffer entries (power of 2, >= 2).
//   PTR_W       log2(FIFO_DEPTH); width of the read/write pointers.
//
// Ports:
//   clk             in   1   system clock, rising edge
//   rst             in   1   synchronous reset, active-low
//   fetch_en        in   1   0 stalls fetch (buffered entries still drain)
//   rom_ce          out  1   ROM chip enable (registered)
//   rom_addr        out  32  ROM byte address, always the PC register
//   rom_inst        in   32  instruction word from ROM for rom_addr
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  redirect target byte address
//   id_valid        out  1   head FIFO entry valid toward decode
//   id_ready        in   1   decode accepts head entry this cycle
//   id_inst         out  32  head instruction, zero when id_valid=0
//   id_pc           out  32  PC of head instruction, zero when id_valid=0
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          PTR_W      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  // The count needs one bit more than the pointers so that "full" can be
  // told apart from "empty".
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      pc_reg,     pc_next;
  logic             rom_ce_reg;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  // Fetch buffer storage. Read is combinational from the head entry, so this
  // is kept in fabric registers rather than block RAM.
  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake / control terms
  // ---------------------------------------------------------------------------
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [FIFO_DEPTH-1:0] wr_en;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // A redirect suppresses the push: the word on rom_inst belongs to the
  // path being abandoned.
  assign push = rom_ce_reg & fetch_en & ~full & ~redirect_valid;

  // A pop coinciding with a redirect is irrelevant because the flush zeroes
  // all FIFO state anyway. It is masked here so the pointer/count update
  // reads clearly.
  assign pop  = ~empty & id_ready & ~redirect_valid;

  // Per-entry write enables decoded from the write pointer.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Low two bits of the redirect target are discarded (word alignment).
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;

    if (redirect_valid) begin
      // Redirect wins over fetch_en=0 and over a full buffer.
      pc_next     = {redirect_pc[31:2], 2'b00};
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;   // wraps modulo 2^32
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg     <= RESET_PC;
      rom_ce_reg <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      // ROM is enabled from the first edge out of reset onward; the word
      // presented during the cycle rom_ce was still 0 is never captured.
      rom_ce_reg <= 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Buffer payload needs no reset: an entry is only visible while count
  // covers it, and every such entry was written by a push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) begin
        pc_mem[i]   <= pc_reg;
        inst_mem[i] <= rom_inst;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rom_ce   = rom_ce_reg;
  assign rom_addr = pc_reg;

  assign id_valid = ~empty;
  assign id_pc    = empty ? 32'h0 : pc_mem[rd_ptr_reg];
  assign id_inst  = empty ? 32'h0 : inst_mem[rd_ptr_reg];

endmodule
